uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO: the next generation of the team's fixed 8N1 serial transmitter. It accepts bytes over a valid/ready handshake, buffers up to DEPTH words, and serialises them LSB-first with configurable data width, parity mode and stop-bit count. Bit timing comes from the shared baud generator's one-cycle `baud_tick` strobe. It sits between the case-conversion datapath and the UART TX pin.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd
- `STOP_BITS`, 1: legal 1 or 2
- `DEPTH`, 4: FIFO entries, power of two, ≥2
- `i_clk`  input  1  system clock, all logic on rising edge
- `i_rst_n`  input  1  asynchronous, active-low reset
- `i_data`  input  DATA_BITS  word to send
- `i_valid`  input  1  i_data valid
- `o_ready`  output  1  FIFO can accept (not full)
- `baud_tick`  input  1  one-cycle strobe per bit period
- `o_out`  output  1  serial line, idle high
- `o_busy`  output  1  frame in progress or FIFO non-empty
- `o_count`  output  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Reset (async assert, sync release): FIFO empty, state IDLE, `o_out`=1, `o_ready`=1, `o_busy`=0, `o_count`=0. Assertion mid-frame aborts the frame at once; the line returns high and buffered words are discarded.
- Push: on the edge where `i_valid && o_ready`, `i_data` is written; words offered while `o_ready`=0 are ignored. A push and a pop in the same cycle are both performed and `o_count` is unchanged.
- States: IDLE, START, DATA, PARITY, STOP. The FSM advances only on cycles with `baud_tick`=1; between ticks `o_out` holds.
- IDLE: `o_out`=1. On a tick with FIFO non-empty, pop the head into the shift register, drive `o_out`=0 and enter START.
- START: on a tick, drive data bit 0 and enter DATA with bit index 0.
- DATA: on each tick, advance to the next bit, LSB first. After bit DATA_BITS-1 has been held for one tick period, go to PARITY if `PARITY`≠0, otherwise to STOP.
- PARITY: drive `^data` (XOR of the data bits) for even parity, `~^data` for odd. On the next tick go to STOP.
- STOP: `o_out`=1 for STOP_BITS tick periods. On the tick that ends the last stop bit:
  - FIFO non-empty: pop the next word and drive its start bit on that same edge (back-to-back frames, no idle gap).
  - FIFO empty: go to IDLE.
- Parity is computed from the popped word held in the shift register, not from the FIFO head.
- `o_busy` = (state≠IDLE) || (`o_count`≠0).

## Timing
- All outputs are registered except `o_ready` (=`o_count`≠DEPTH) and `o_busy`, which are decoded from registers only.
- Frame length = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS tick periods; 10 for 8N1.
- Latency from push into an empty idle block to the start bit is the first `baud_tick` strictly after the push edge, plus zero cycles. A push and a tick on the same edge do not start a frame.
- `o_count` updates on the edge after a push or pop. A pop and a full-to-not-full transition raise `o_ready` on the same edge.
- A `baud_tick` held high for several cycles counts as one advance per cycle; the baud generator guarantees single-cycle pulses.
- Wrap-around: read and write pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by `o_count`.

## Test plan
- 8N1, ticks every 16 clocks, push 0x41 → `o_out` per tick: 0,1,0,0,0,0,0,1,0,1, then stays 1; `o_busy` falls on the edge that enters IDLE.
- PARITY=1 (even), push 0x41 → parity bit 0; PARITY=2 (odd), push 0x41 → parity bit 1; STOP_BITS=2 → line high for 2 tick periods before IDLE.
- DEPTH=4, push 0x11,0x22,0x33,0x44,0x55 with no ticks → first four accepted, `o_ready`=0, `o_count`=4, 0x55 dropped; with ticks enabled, four back-to-back frames with no idle bit between them.
- FIFO full and a pop occurring while `i_valid`=1 → word not accepted that cycle (`o_ready` was 0); accepted next cycle; `o_count` returns to 4.
- DATA_BITS=7, push 0x7F → 0, seven 1s, stop 1; the bit above bit 6 of the input is never transmitted.
- Assert `i_rst_n`=0 mid-DATA with 2 words queued → `o_out`=1 immediately (asynchronous); after release, `o_count`=0, `o_busy`=0, no frame emitted on subsequent ticks.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter behind a DEPTH-word FIFO; frames go out LSB-first, one bit per baud_tick.
// Start bit on the first tick after a push into an idle block; o_ready drops only while the FIFO is full.
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [DATA_BITS-1:0]   i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   baud_tick,
  output logic                   o_out,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [DATA_BITS-1:0] shreg;
  logic [IW-1:0]        bit_idx;
  logic                 stop_cnt;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic                 last_stop;

  assign fifo_empty = (o_count == '0);
  assign o_ready    = (o_count != FULL_CNT);
  assign push       = i_valid && o_ready;
  assign last_stop  = (state == S_STOP) && (stop_cnt == 1'(STOP_BITS - 1));
  // A pop only ever happens on a tick, from IDLE or from the tick closing the last stop bit.
  assign pop        = baud_tick && !fifo_empty && ((state == S_IDLE) || last_stop);
  assign o_busy     = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end

  // Parity is taken from the whole captured word, so shreg is indexed rather than shifted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      o_out    <= 1'b1;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
    end else if (baud_tick) begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shreg <= mem[rd_ptr];
            o_out <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          o_out   <= shreg[0];
          bit_idx <= '0;
          state   <= S_DATA;
        end
        S_DATA: begin
          if (bit_idx == IW'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              o_out <= (PARITY == 1) ? ^shreg : ~^shreg;
              state <= S_PARITY;
            end else begin
              o_out    <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= S_STOP;
            end
          end else begin
            bit_idx <= bit_idx + 1'b1;
            o_out   <= shreg[bit_idx + 1'b1];
          end
        end
        S_PARITY: begin
          o_out    <= 1'b1;
          stop_cnt <= 1'b0;
          state    <= S_STOP;
        end
        S_STOP: begin
          if (last_stop) begin
            if (pop) begin
              shreg <= mem[rd_ptr];
              o_out <= 1'b0;
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            stop_cnt <= 1'b1;
          end
        end
        default: begin
          o_out <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Four uart_tx_fifo configurations (8N1, 8E1, 8O2, 7N1) on shared stimulus, checked by a
// frame scoreboard fed from a tick-level queue model and a negedge monitor.
module tb_uart_tx_fifo;

  localparam int NI    = 4;
  localparam int DEPTH = 4;

  typedef struct {
    int          inst;
    logic [15:0] frame;
    int          st;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_dat;
  logic       in_vld;
  logic       baud_tick;
  logic [NI-1:0] line;
  logic [NI-1:0] rdy;
  logic [NI-1:0] busy;
  logic [2:0]    cnt [NI];

  int n_chk  = 0;
  int n_pass = 0;

  // stimulus control
  int   cyc      = 0;
  int   tick_per = 16;
  logic tick_en  = 1'b0;
  logic rnd_en   = 1'b0;
  logic prev_tick = 1'b0;

  // reference model state
  int   mcnt [NI];
  int   mbusy [NI];
  int   tick_no = 0;
  logic tick_q  = 1'b0;
  exp_t sbq [$];

  // monitor state
  exp_t        cur [NI];
  logic [15:0] rx_bits [NI];
  int          rx_n [NI];
  logic        prev_line [NI];
  int          frames_done [NI];

  logic [31:0] seq [NI];
  logic [31:0] bsq [NI];

  uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(DEPTH)) u_8n1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(in_dat), .i_valid(in_vld), .o_ready(rdy[0]),
    .baud_tick(baud_tick), .o_out(line[0]), .o_busy(busy[0]), .o_count(cnt[0]));
  uart_tx_fifo #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DEPTH(DEPTH)) u_8e1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(in_dat), .i_valid(in_vld), .o_ready(rdy[1]),
    .baud_tick(baud_tick), .o_out(line[1]), .o_busy(busy[1]), .o_count(cnt[1]));
  uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .DEPTH(DEPTH)) u_8o2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(in_dat), .i_valid(in_vld), .o_ready(rdy[2]),
    .baud_tick(baud_tick), .o_out(line[2]), .o_busy(busy[2]), .o_count(cnt[2]));
  uart_tx_fifo #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .DEPTH(DEPTH)) u_7n1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(in_dat[6:0]), .i_valid(in_vld), .o_ready(rdy[3]),
    .baud_tick(baud_tick), .o_out(line[3]), .o_busy(busy[3]), .o_count(cnt[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dbits(int i);
    return (i == 3) ? 7 : 8;
  endfunction
  function automatic int pmode(int i);
    return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
  endfunction
  function automatic int sbits(int i);
    return (i == 2) ? 2 : 1;
  endfunction
  function automatic int flen(int i);
    return 1 + dbits(i) + ((pmode(i) != 0) ? 1 : 0) + sbits(i);
  endfunction

  // Line value for each tick period of a frame, bit k = period k; unused upper bits idle high.
  function automatic logic [15:0] mk_frame(int i, logic [7:0] d);
    logic [15:0] f;
    int   n;
    logic p;
    f = '1;
    p = 1'b0;
    f[0] = 1'b0;
    n = 1;
    for (int k = 0; k < dbits(i); k++) begin
      f[n] = d[k];
      p    = p ^ d[k];
      n++;
    end
    if (pmode(i) == 1) f[n] = p;
    else if (pmode(i) == 2) f[n] = ~p;
    return f;
  endfunction

  function automatic logic model_idle();
    logic r;
    r = 1'b1;
    for (int i = 0; i < NI; i++) begin
      if (mcnt[i] != 0 || mbusy[i] != 0) r = 1'b0;
    end
    return r;
  endfunction

  task automatic chk(string name, int idx, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic bound_fail(string name);
    n_chk++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Model: each word occupies the line for flen ticks; the tick closing a frame (or any idle
  // tick) takes the next queued word. Pushes use the occupancy seen before the edge.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        mcnt[i]  = 0;
        mbusy[i] = 0;
      end
      sbq.delete();
      tick_q = 1'b0;
    end else begin
      tick_q = baud_tick;
      if (baud_tick) tick_no++;
      for (int i = 0; i < NI; i++) begin
        int   pre;
        exp_t e;
        pre = mcnt[i];
        if (baud_tick) begin
          if (mbusy[i] > 1) begin
            mbusy[i]--;
          end else if (pre != 0) begin
            mcnt[i]--;
            mbusy[i] = flen(i);
            for (int k = 0; k < sbq.size(); k++) begin
              if (sbq[k].inst == i && sbq[k].st < 0) begin
                sbq[k].st = tick_no;
                break;
              end
            end
          end else begin
            mbusy[i] = 0;
          end
        end
        if (in_vld && pre < DEPTH) begin
          mcnt[i]++;
          e.inst  = i;
          e.frame = mk_frame(i, in_dat);
          e.st    = -1;
          sbq.push_back(e);
        end
      end
    end
  end

  // Monitor: status every cycle, line hold between ticks, frames reassembled per tick.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        rx_n[i]      = 0;
        prev_line[i] = 1'b1;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        chk("count", i, int'(cnt[i]), mcnt[i]);
        chk("ready", i, int'(rdy[i]), int'(mcnt[i] < DEPTH));
        chk("busy", i, int'(busy[i]), int'(mbusy[i] != 0 || mcnt[i] != 0));
        if (tick_q) begin
          if (rx_n[i] == 0) begin
            if (line[i] == 1'b0) begin
              int found;
              found = 0;
              for (int k = 0; k < sbq.size(); k++) begin
                if (sbq[k].inst == i) begin
                  cur[i] = sbq[k];
                  sbq.delete(k);
                  found = 1;
                  break;
                end
              end
              chk("frame_expected", i, found, 1);
              if (found != 0) begin
                chk("start_tick", i, tick_no, cur[i].st);
                rx_bits[i]    = '1;
                rx_bits[i][0] = 1'b0;
                rx_n[i]       = 1;
              end
            end
          end else begin
            rx_bits[i][rx_n[i]] = line[i];
            rx_n[i]++;
            if (rx_n[i] == flen(i)) begin
              chk("frame", i, int'(rx_bits[i]), int'(cur[i].frame));
              frames_done[i]++;
              rx_n[i] = 0;
            end
          end
        end else begin
          chk("hold", i, int'(line[i]), int'(prev_line[i]));
        end
        prev_line[i] = line[i];
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic force_tick);
    @(negedge clk);
    prev_tick = baud_tick;
    cyc++;
    in_vld    = v;
    in_dat    = d;
    baud_tick = force_tick || (tick_en && (cyc % tick_per == 0)) ||
                (rnd_en && ($urandom_range(0, 3) == 0));
  endtask

  task automatic push_one(input logic [7:0] d);
    step(1'b1, d, 1'b0);
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic capture(input int nt);
    int k;
    int guard;
    k = 0;
    guard = 0;
    while (k < nt && guard < 4000) begin
      step(1'b0, 8'h00, 1'b0);
      guard++;
      if (prev_tick) begin
        for (int i = 0; i < NI; i++) begin
          seq[i][k] = line[i];
          bsq[i][k] = busy[i];
        end
        k++;
      end
    end
    if (k < nt) bound_fail("capture");
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    tick_en = 1'b1;
    rnd_en  = 1'b0;
    while (!model_idle() && guard < 5000) begin
      step(1'b0, 8'h00, 1'b0);
      guard++;
    end
    if (!model_idle()) bound_fail("drain");
    step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fd;
    logic [7:0] d7 [2];
    int         exp_d [2];
    int         exp_a [2];

    rst_n = 1'b0;
    in_vld = 1'b0;
    in_dat = 8'h00;
    baud_tick = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("reset_line", i, int'(line[i]), 1);
      chk("reset_ready", i, int'(rdy[i]), 1);
      chk("reset_busy", i, int'(busy[i]), 0);
      chk("reset_count", i, int'(cnt[i]), 0);
    end
    rst_n = 1'b1;
    tick_per = 16;
    tick_en = 1'b1;
    step(1'b0, 8'h00, 1'b0);

    // 0x41 through all four configurations
    push_one(8'h41);
    capture(13);
    chk("8n1_line", 0, int'(seq[0][10:0]), 'h682);
    chk("8n1_busy_stop", 0, int'(bsq[0][9]), 1);
    chk("8n1_busy_idle", 0, int'(bsq[0][10]), 0);
    chk("8e1_parity", 1, int'(seq[1][9]), 0);
    chk("8e1_busy_stop", 1, int'(bsq[1][10]), 1);
    chk("8e1_busy_idle", 1, int'(bsq[1][11]), 0);
    chk("8o2_parity", 2, int'(seq[2][9]), 1);
    chk("8o2_stop2", 2, int'(seq[2][11:10]), 3);
    chk("8o2_busy_stop2", 2, int'(bsq[2][11]), 1);
    chk("8o2_busy_idle", 2, int'(bsq[2][12]), 0);
    chk("7n1_line", 3, int'(seq[3][8:0]), 'h182);
    chk("7n1_busy_idle", 3, int'(bsq[3][9]), 0);

    // bit 7 of the bus must never reach the 7-bit line
    d7[0] = 8'h80; exp_d[0] = 'h100; exp_a[0] = 'h700;
    d7[1] = 8'h7F; exp_d[1] = 'h1FE; exp_a[1] = 'h6FE;
    for (int j = 0; j < 2; j++) begin
      drain();
      push_one(d7[j]);
      capture(13);
      chk("7n1_width", j, int'(seq[3][9:0]), exp_d[j] | 'h200);
      chk("8n1_width", j, int'(seq[0][10:0]), exp_a[j]);
    end

    // overfill with no ticks, then four back-to-back frames
    drain();
    tick_en = 1'b0;
    for (int j = 0; j < 5; j++) step(1'b1, 8'(17 * (j + 1)), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < NI; i++) begin
      chk("full_count", i, int'(cnt[i]), 4);
      chk("full_ready", i, int'(rdy[i]), 0);
    end
    fd = frames_done[0];
    drain();
    chk("full_frames", 0, frames_done[0] - fd, 4);

    // pop from full while a word is offered: rejected that edge, taken the next
    tick_en = 1'b0;
    for (int j = 0; j < 4; j++) step(1'b1, 8'hA1 + 8'(j), 1'b0);
    step(1'b1, 8'h66, 1'b1);
    step(1'b1, 8'h66, 1'b0);
    chk("pop_ready", 0, int'(rdy[0]), 1);
    chk("pop_count", 0, int'(cnt[0]), 3);
    step(1'b0, 8'h00, 1'b0);
    chk("refill_count", 0, int'(cnt[0]), 4);
    chk("refill_ready", 0, int'(rdy[0]), 0);
    drain();

    // reset in the middle of DATA with two words queued
    for (int j = 0; j < 3; j++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    capture(5);
    chk("pre_rst_count", 0, int'(cnt[0]), 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    baud_tick = 1'b0;
    in_vld = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_line", i, int'(line[i]), 1);
      chk("rst_count", i, int'(cnt[i]), 0);
      chk("rst_busy", i, int'(busy[i]), 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fd = frames_done[0] + frames_done[1] + frames_done[2] + frames_done[3];
    capture(20);
    for (int i = 0; i < NI; i++) begin
      chk("post_rst_line", i, int'(seq[i][19:0]), 'hFFFFF);
      chk("post_rst_count", i, int'(cnt[i]), 0);
      chk("post_rst_busy", i, int'(busy[i]), 0);
    end
    chk("post_rst_frames", 0, frames_done[0] + frames_done[1] + frames_done[2] + frames_done[3], fd);

    // random traffic with random single-cycle and back-to-back ticks
    tick_en = 1'b0;
    rnd_en = 1'b1;
    for (int j = 0; j < 3000; j++) step($urandom_range(0, 2) == 0, 8'($urandom), 1'b0);
    tick_per = 5;
    drain();
    chk("sb_empty", 0, sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
